write_resp_router: RTL and testbench
====================================

WRITE_RESP_ROUTER -- requirements
Module: write_resp_router

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 2, number of upstream masters receiving B responses (legal 2..16).
REQ-002 The block SHALL have parameter ID_W, default 1, width of master ID from the write-response queue; ID_W >= clog2(NUM_MASTERS).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 Resp_Master_ID  input  ID_W  master ID at head of the write-response queue.
REQ-006 Resp_Master_Valid  input  1  queue head valid (queue not empty).
REQ-007 Write_Resp_Finsh  output  1  one-cycle pulse popping the queue head.
REQ-008 S_BRESP  input  2  slave write response code.
REQ-009 S_BVALID  input  1  slave response valid.
REQ-010 S_BREADY  output  1  router ready for slave response.
REQ-011 M_BRESP  output  2*NUM_MASTERS  per-master response, lane i = bits [2i+1:2i].
REQ-012 M_BVALID  output  NUM_MASTERS  per-master response valid.
REQ-013 M_BREADY  input  NUM_MASTERS  per-master response ready.
REQ-014 Drop_Count  output  8  count of responses dropped for out-of-range IDs.

Function
REQ-015 The block SHALL implement a four-state FSM: IDLE, ACCEPT, SEND, FINISH.
REQ-016 IDLE: S_BREADY=0, all M_BVALID=0; if Resp_Master_Valid=1, latch Resp_Master_ID into id_q and go to ACCEPT next cycle; else stay.
REQ-017 ACCEPT: S_BREADY=1; on S_BVALID=1, latch S_BRESP into resp_q; go to SEND if id_q < NUM_MASTERS, else go to FINISH and increment Drop_Count.
REQ-018 ACCEPT with S_BVALID=0 SHALL hold ACCEPT indefinitely; changes on Resp_Master_ID/Resp_Master_Valid after latching SHALL be ignored.
REQ-019 SEND: S_BREADY=0; M_BVALID[id_q]=1, M_BRESP lane id_q = resp_q; all other M_BVALID bits and M_BRESP lanes = 0.
REQ-020 SEND SHALL hold M_BVALID and M_BRESP stable until M_BREADY[id_q]=1, then go to FINISH; M_BREADY of other lanes SHALL be ignored.
REQ-021 FINISH: Write_Resp_Finsh=1 for exactly this one cycle, all M_BVALID=0, S_BREADY=0; unconditional transition to IDLE.
REQ-022 Write_Resp_Finsh SHALL be 0 in every state other than FINISH; exactly one pulse per accepted slave response.
REQ-023 All outputs SHALL be decoded from registered state only (Moore); no combinational path from any input to any output.
REQ-024 Latency: slave handshake in cycle N -> M_BVALID high in cycle N+1; master handshake in cycle M -> Write_Resp_Finsh high in cycle M+1, IDLE in M+2.
REQ-025 IDLE following FINISH SHALL sample the post-pop queue head; back-to-back responses SHALL each take a full IDLE-ACCEPT-SEND-FINISH pass.
REQ-026 S_BVALID while in IDLE, SEND or FINISH SHALL not be accepted (S_BREADY=0); response held by slave.
REQ-027 Drop_Count SHALL increment by 1 per out-of-range response and saturate at 255.

Reset
REQ-028 reset_n=0 at a rising edge SHALL force state IDLE, id_q=0, resp_q=0, Drop_Count=0.
REQ-029 During and after reset: S_BREADY=0, M_BVALID=0, M_BRESP=0, Write_Resp_Finsh=0.
REQ-030 Reset in SEND or ACCEPT SHALL discard the pending response with no Finsh pulse and no Drop_Count change.

Verification
REQ-031 Head ID=1 valid, S_BRESP=2'b00 S_BVALID=1, M_BREADY=2'b11 -> M_BVALID=2'b10 one cycle after slave handshake, M_BRESP[3:2]=00, one Finsh pulse next cycle.
REQ-032 Head ID=0, S_BRESP=2'b10, M_BREADY[0]=0 for 5 cycles then 1 -> M_BVALID[0] and M_BRESP[1:0]=10 stable all 6 cycles, Finsh once after.
REQ-033 NUM_MASTERS=3, ID_W=2, head ID=3 -> response consumed, M_BVALID stays 0, Finsh pulses, Drop_Count 0->1; 300 such responses -> Drop_Count=255.
REQ-034 S_BVALID=1 with Resp_Master_Valid=0 for 10 cycles -> S_BREADY=0 throughout, no outputs change.
REQ-035 Four queued IDs 0,1,1,0 with slave responses OKAY,SLVERR,OKAY,DECERR -> delivered in order to correct lanes with matching codes, exactly four Finsh pulses.
REQ-036 reset_n=0 asserted while in SEND -> next cycle all outputs 0, no Finsh pulse; after release, normal operation resumes from IDLE.

Source files
------------

// File: rtl/write_resp_router.sv
// Write-response router: steers one slave B response at a time to the
// master named at the head of the write-response queue, then pops it.
module write_resp_router #(
  parameter int NUM_MASTERS = 2,
  parameter int ID_W        = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ID_W-1:0]          Resp_Master_ID,
  input  logic                     Resp_Master_Valid,
  output logic                     Write_Resp_Finsh,
  input  logic [1:0]               S_BRESP,
  input  logic                     S_BVALID,
  output logic                     S_BREADY,
  output logic [2*NUM_MASTERS-1:0] M_BRESP,
  output logic [NUM_MASTERS-1:0]   M_BVALID,
  input  logic [NUM_MASTERS-1:0]   M_BREADY,
  output logic [7:0]               Drop_Count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    SEND,
    FINISH
  } state_t;

  state_t                   state;
  logic [ID_W-1:0]          id_q;
  logic [1:0]               resp_q;
  logic [NUM_MASTERS-1:0]   sel;
  logic [2*NUM_MASTERS-1:0] lane_resp;
  logic                     in_range;
  logic                     lane_ready;

  // Decode the latched ID into a lane select and the response lane image.
  always_comb begin
    sel       = '0;
    lane_resp = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sel[i] = (id_q == ID_W'(i));
      lane_resp[2*i +: 2] = sel[i] ? S_BRESP : 2'b00;
    end
    in_range   = (32'(id_q) < 32'(NUM_MASTERS));
    lane_ready = |(M_BREADY & sel);
  end

  // Router FSM; every output is a register loaded for the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      id_q             <= '0;
      resp_q           <= '0;
      Drop_Count       <= '0;
      S_BREADY         <= 1'b0;
      M_BVALID         <= '0;
      M_BRESP          <= '0;
      Write_Resp_Finsh <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Resp_Master_Valid) begin
            id_q     <= Resp_Master_ID;
            S_BREADY <= 1'b1;
            state    <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (S_BVALID) begin
            resp_q   <= S_BRESP;
            S_BREADY <= 1'b0;
            if (in_range) begin
              M_BVALID <= sel;
              M_BRESP  <= lane_resp;
              state    <= SEND;
            end else begin
              Write_Resp_Finsh <= 1'b1;
              if (Drop_Count != 8'hFF)
                Drop_Count <= Drop_Count + 8'd1;
              state <= FINISH;
            end
          end
        end
        SEND: begin
          if (lane_ready) begin
            M_BVALID         <= '0;
            M_BRESP          <= '0;
            Write_Resp_Finsh <= 1'b1;
            state            <= FINISH;
          end
        end
        FINISH: begin
          Write_Resp_Finsh <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          S_BREADY         <= 1'b0;
          M_BVALID         <= '0;
          M_BRESP          <= '0;
          Write_Resp_Finsh <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_resp_router.sv
// Directed bench for write_resp_router with a cycle-level reference model
// and a per-cycle output compare against it.
module tb_write_resp_router;

  localparam int NM = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [IW-1:0] head_id;
  logic          head_valid;
  logic          finsh;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready;
  logic [2*NM-1:0] m_bresp;
  logic [NM-1:0] m_bvalid;
  logic [NM-1:0] m_bready;
  logic [7:0]    drop_count;

  int n_chk  = 0;
  int n_fail = 0;
  int n_finsh = 0;
  logic [3:0] dq[$];

  write_resp_router #(.NUM_MASTERS(NM), .ID_W(IW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .Resp_Master_ID    (head_id),
    .Resp_Master_Valid (head_valid),
    .Write_Resp_Finsh  (finsh),
    .S_BRESP           (s_bresp),
    .S_BVALID          (s_bvalid),
    .S_BREADY          (s_bready),
    .M_BRESP           (m_bresp),
    .M_BVALID          (m_bvalid),
    .M_BREADY          (m_bready),
    .Drop_Count        (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction walks wait_head -> wait_slave ->
  // offer (in-range only) -> pop, one step per clock.
  localparam int WAIT_HEAD  = 10;
  localparam int WAIT_SLAVE = 20;
  localparam int OFFER      = 30;
  localparam int POP        = 40;

  int  m_step = WAIT_HEAD;
  int  m_id   = 0;
  int  m_code = 0;
  int  m_drop = 0;
  bit  m_live = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_step = WAIT_HEAD;
      m_id   = 0;
      m_code = 0;
      m_drop = 0;
    end else if (m_step == WAIT_HEAD) begin
      if (head_valid) begin
        m_id   = int'(head_id);
        m_step = WAIT_SLAVE;
      end
    end else if (m_step == WAIT_SLAVE) begin
      if (s_bvalid) begin
        m_code = int'(s_bresp);
        if (m_id < NM) m_step = OFFER;
        else begin
          m_step = POP;
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
      end
    end else if (m_step == OFFER) begin
      if (m_bready[m_id]) m_step = POP;
    end else begin
      m_step = WAIT_HEAD;
    end
    m_live = 1;
  end

  // Compare every cycle, and log deliveries and pops seen on the pins.
  always @(negedge clk) begin
    if (m_live) begin
      chk("s_bready", 32'(s_bready), 32'(m_step == WAIT_SLAVE));
      chk("finsh", 32'(finsh), 32'(m_step == POP));
      chk("m_bvalid", 32'(m_bvalid),
          (m_step == OFFER) ? (32'd1 << m_id) : 32'd0);
      chk("m_bresp", 32'(m_bresp),
          (m_step == OFFER) ? (32'(m_code) << (2 * m_id)) : 32'd0);
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      if (finsh === 1'b1) n_finsh++;
      for (int i = 0; i < NM; i++)
        if (m_bvalid[i] === 1'b1 && m_bready[i] === 1'b1)
          dq.push_back({2'(i), m_bresp[2*i +: 2]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One queued response: head ID, slave code, cycles the master stalls.
  task automatic txn(input logic [IW-1:0] id, input logic [1:0] code,
                     input int hold);
    logic [NM-1:0] oh;
    oh = '0;
    if (int'(id) < NM) oh[id] = 1'b1;
    head_id = id; head_valid = 1'b1;
    s_bvalid = 1'b0; m_bready = '0;
    step();
    head_valid = 1'b0; head_id = ~id;
    s_bresp = code; s_bvalid = 1'b1;
    step();
    s_bvalid = 1'b0; s_bresp = ~code;
    if (int'(id) < NM) begin
      chk("send_valid", 32'(m_bvalid), 32'(oh));
      for (int k = 0; k < hold; k++) begin
        m_bready = ~oh;
        s_bvalid = 1'b1;
        step();
        chk("hold_valid", 32'(m_bvalid), 32'(oh));
      end
      s_bvalid = 1'b0;
      m_bready = oh;
      step();
      m_bready = '0;
    end else begin
      chk("drop_valid", 32'(m_bvalid), 32'd0);
    end
    chk("finsh_pulse", 32'(finsh), 32'd1);
    step();
    chk("finsh_gone", 32'(finsh), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; head_id = '0; head_valid = 1'b0;
    s_bresp = 2'b00; s_bvalid = 1'b0; m_bready = '0;
    step(); step();
    chk("rst_bready", 32'(s_bready), 32'd0);
    chk("rst_bvalid", 32'(m_bvalid), 32'd0);
    chk("rst_bresp", 32'(m_bresp), 32'd0);
    chk("rst_finsh", 32'(finsh), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset_n = 1'b1;
    step();

    // slave presents a response with an empty queue
    s_bvalid = 1'b1; s_bresp = 2'b11;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_bready", 32'(s_bready), 32'd0);
      chk("idle_bvalid", 32'(m_bvalid), 32'd0);
    end
    s_bvalid = 1'b0;

    // ID 1, OKAY, master always ready
    head_id = 2'd1; head_valid = 1'b1; m_bready = 3'b111;
    step();
    head_valid = 1'b0;
    s_bresp = 2'b00; s_bvalid = 1'b1;
    step();
    s_bvalid = 1'b0;
    chk("t1_bvalid", 32'(m_bvalid), 32'h2);
    chk("t1_bresp", 32'(m_bresp[3:2]), 32'h0);
    step();
    chk("t1_finsh", 32'(finsh), 32'd1);
    m_bready = '0;
    step();
    chk("t1_finsh_off", 32'(finsh), 32'd0);

    // ID 0, SLVERR, master stalls five cycles
    txn(2'd0, 2'b10, 5);

    dq.delete();
    txn(2'd0, 2'b00, 0);
    txn(2'd1, 2'b10, 2);
    txn(2'd1, 2'b00, 0);
    txn(2'd0, 2'b11, 1);
    chk("order_n", 32'(dq.size()), 32'd4);
    if (dq.size() == 4) begin
      chk("order_0", 32'(dq[0]), 32'h0);
      chk("order_1", 32'(dq[1]), 32'h6);
      chk("order_2", 32'(dq[2]), 32'h4);
      chk("order_3", 32'(dq[3]), 32'h3);
    end

    // reset while offering to master 0
    head_id = 2'd0; head_valid = 1'b1;
    step();
    head_valid = 1'b0;
    s_bresp = 2'b01; s_bvalid = 1'b1;
    step();
    s_bvalid = 1'b0;
    chk("rs_send", 32'(m_bvalid), 32'h1);
    reset_n = 1'b0;
    step();
    chk("rs_bvalid", 32'(m_bvalid), 32'd0);
    chk("rs_bresp", 32'(m_bresp), 32'd0);
    chk("rs_finsh", 32'(finsh), 32'd0);
    reset_n = 1'b1;
    step();
    chk("rs_idle_finsh", 32'(finsh), 32'd0);

    txn(2'd2, 2'b01, 0);

    txn(2'd3, 2'b10, 0);
    chk("drop_one", 32'(drop_count), 32'd1);
    for (int k = 0; k < 299; k++) txn(2'd3, 2'(k), 0);
    chk("drop_sat", 32'(drop_count), 32'd255);

    step();
    chk("finsh_total", 32'(n_finsh), 32'd307);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
